// File: rtl/response_checker_pkg.sv
// Shared types and helpers for the in-order response checker.
package response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  // Ceiling log2, used to size FIFO pointers from DEPTH.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/response_checker_if.sv
// Control, stream and result signals of the response checker.
interface response_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) ();

  logic              i_start;
  logic              i_stop;
  logic              i_exp_valid;
  logic [DATA_W-1:0] i_exp_data;
  logic              o_exp_ready;
  logic              i_act_valid;
  logic [DATA_W-1:0] i_act_data;
  logic [CNT_W-1:0]  o_pass_cnt;
  logic [CNT_W-1:0]  o_fail_cnt;
  logic [CNT_W-1:0]  o_missing_cnt;
  logic [CNT_W-1:0]  o_first_fail_idx;
  logic [DATA_W-1:0] o_first_fail_exp;
  logic [DATA_W-1:0] o_first_fail_act;
  logic              o_mismatch;
  logic              o_underflow;
  logic              o_done;

  modport master (
    output i_start, i_stop, i_exp_valid, i_exp_data, i_act_valid, i_act_data,
    input  o_exp_ready, o_pass_cnt, o_fail_cnt, o_missing_cnt,
           o_first_fail_idx, o_first_fail_exp, o_first_fail_act,
           o_mismatch, o_underflow, o_done
  );

  modport slave (
    input  i_start, i_stop, i_exp_valid, i_exp_data, i_act_valid, i_act_data,
    output o_exp_ready, o_pass_cnt, o_fail_cnt, o_missing_cnt,
           o_first_fail_idx, o_first_fail_exp, o_first_fail_act,
           o_mismatch, o_underflow, o_done
  );

endinterface

// File: rtl/response_checker_sync_fifo.sv
// Synchronous FIFO holding pending expected values; registered full/empty.
module sync_fifo
  import response_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = log2c(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;
  logic [AW:0]       count_nxt;

  // Qualify requests against the registered flags and form the next occupancy.
  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers, occupancy and flags; clear has priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/response_checker.sv
// In-order scoreboard: queues expected values, compares DUT samples against
// the oldest pending entry and keeps saturating pass/fail statistics.
module response_checker
  import response_checker_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  response_checker_if.slave bus
);

  localparam int unsigned AW = log2c(DEPTH);

  chk_state_e        state;
  logic [31:0]       tmr;

  logic              fifo_clr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [AW:0]       fifo_count;

  logic              cmp_valid;
  logic              hit_head;
  logic              under_now;
  logic              pass_now;
  logic              fail_now;
  logic              drain_exit;
  logic              exp_ready;

  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic [CNT_W-1:0]  missing_cnt;
  logic [CNT_W-1:0]  sample_idx;
  logic [CNT_W-1:0]  ff_idx;
  logic [DATA_W-1:0] ff_exp;
  logic [DATA_W-1:0] ff_act;
  logic              first_seen;
  logic              mismatch_q;
  logic              underflow_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (bus.i_exp_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Compare-stage decode; a push into an empty FIFO is never bypassed to the
  // head, so a same-cycle sample sees an empty queue and counts as underflow.
  always_comb begin
    exp_ready  = (state == ST_RUN) && !fifo_full;
    fifo_push  = bus.i_exp_valid && exp_ready;
    cmp_valid  = ((state == ST_RUN) || (state == ST_DRAIN)) &&
                 bus.i_act_valid && !bus.i_start;
    hit_head   = cmp_valid && !fifo_empty;
    under_now  = cmp_valid && fifo_empty;
    pass_now   = hit_head && (fifo_dout == bus.i_act_data);
    fail_now   = under_now || (hit_head && (fifo_dout != bus.i_act_data));
    fifo_pop   = hit_head;
    drain_exit = (state == ST_DRAIN) && !bus.i_start &&
                 (fifo_empty || (!bus.i_act_valid && (tmr == 32'(TIMEOUT - 1))));
    fifo_clr   = bus.i_start || drain_exit;
  end

  // Control FSM with drain idle timer; missing count captured on DONE entry.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      missing_cnt <= '0;
    end else if (bus.i_start) begin
      state       <= ST_RUN;
      tmr         <= '0;
      missing_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.i_stop) begin
            state <= ST_DRAIN;
            tmr   <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_exit) begin
            state       <= ST_DONE;
            missing_cnt <= CNT_W'(fifo_count);
          end else if (bus.i_act_valid) begin
            tmr <= '0;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Statistics and first-failure capture, one cycle behind the sample.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      sample_idx  <= '0;
      ff_idx      <= '0;
      ff_exp      <= '0;
      ff_act      <= '0;
      first_seen  <= 1'b0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.i_start) begin
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      sample_idx  <= '0;
      ff_idx      <= '0;
      ff_exp      <= '0;
      ff_act      <= '0;
      first_seen  <= 1'b0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mismatch_q <= fail_now;
      if (under_now) underflow_q <= 1'b1;
      if (cmp_valid) sample_idx <= CNT_W'(sat_inc(32'(sample_idx), CNT_W));
      if (pass_now)  pass_cnt   <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
      if (fail_now) begin
        fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
        if (!first_seen) begin
          first_seen <= 1'b1;
          ff_idx     <= sample_idx;
          ff_exp     <= under_now ? '0 : fifo_dout;
          ff_act     <= bus.i_act_data;
        end
      end
    end
  end

  assign bus.o_exp_ready      = exp_ready;
  assign bus.o_pass_cnt       = pass_cnt;
  assign bus.o_fail_cnt       = fail_cnt;
  assign bus.o_missing_cnt    = missing_cnt;
  assign bus.o_first_fail_idx = ff_idx;
  assign bus.o_first_fail_exp = ff_exp;
  assign bus.o_first_fail_act = ff_act;
  assign bus.o_mismatch       = mismatch_q;
  assign bus.o_underflow      = underflow_q;
  assign bus.o_done           = (state == ST_DONE);

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker: vector table plus corner sequences.
module tb_response_checker;

  logic i_clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  response_checker_if #(.DATA_W(8), .CNT_W(16)) bus ();

  response_checker #(
    .DATA_W  (8),
    .DEPTH   (8),
    .CNT_W   (16),
    .TIMEOUT (16)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        ev;
    logic [7:0]  ed;
    logic        av;
    logic [7:0]  ad;
    logic [15:0] e_pass;
    logic [15:0] e_fail;
    logic        e_mm;
    logic        e_rdy;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_in();
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_exp_valid = 1'b0;
    bus.i_exp_data  = '0;
    bus.i_act_valid = 1'b0;
    bus.i_act_data  = '0;
  endtask

  function automatic logic any_out();
    return |{bus.o_pass_cnt, bus.o_fail_cnt, bus.o_missing_cnt, bus.o_first_fail_idx,
             bus.o_first_fail_exp, bus.o_first_fail_act, bus.o_mismatch,
             bus.o_underflow, bus.o_done, bus.o_exp_ready};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_idle;
    n_chk  = 0;
    n_fail = 0;

    //                start stop ev  ed  av  ad  pass fail mm rdy
    tv[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd5, 16'd1, 16'd0, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd6, 16'd2, 16'd0, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd7, 16'd3, 16'd0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 16'd1, 16'd0, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 16'd1, 16'd1, 1'b1, 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 16'd2, 16'd1, 1'b0, 1'b1};
    tv[14] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd2, 16'd1, 1'b0, 1'b1};

    idle_in();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("reset_outputs", 32'(any_out()), 0);

    // No start: valids must be ignored
    for (int i = 0; i < 20; i++) begin
      bus.i_exp_valid = 1'b1;
      bus.i_exp_data  = 8'($urandom);
      bus.i_act_valid = 1'($urandom_range(0, 1));
      bus.i_act_data  = 8'($urandom);
      cyc();
      chk("idle_quiet", 32'(any_out()), 0);
    end
    idle_in();
    cyc();

    // Vector table: match run, restart, one mismatch
    for (int i = 0; i < 15; i++) begin
      bus.i_start     = tv[i].start;
      bus.i_stop      = tv[i].stop;
      bus.i_exp_valid = tv[i].ev;
      bus.i_exp_data  = tv[i].ed;
      bus.i_act_valid = tv[i].av;
      bus.i_act_data  = tv[i].ad;
      cyc();
      chk("tv_pass",     32'(bus.o_pass_cnt),  32'(tv[i].e_pass));
      chk("tv_fail",     32'(bus.o_fail_cnt),  32'(tv[i].e_fail));
      chk("tv_mismatch", 32'(bus.o_mismatch),  32'(tv[i].e_mm));
      chk("tv_ready",    32'(bus.o_exp_ready), 32'(tv[i].e_rdy));
    end
    idle_in();
    chk("ff_idx",    32'(bus.o_first_fail_idx), 1);
    chk("ff_exp",    32'(bus.o_first_fail_exp), 2);
    chk("ff_act",    32'(bus.o_first_fail_act), 9);
    chk("tv_no_underflow", 32'(bus.o_underflow), 0);

    // Fill to capacity, hold 9th, pop frees slot only on the next cycle
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.i_exp_valid = 1'b1;
      bus.i_exp_data  = 8'(10 + k);
      cyc();
    end
    bus.i_exp_data = 8'd18;
    chk("full_ready", 32'(bus.o_exp_ready), 0);
    cyc();
    chk("held_ready0", 32'(bus.o_exp_ready), 0);
    cyc();
    chk("held_ready1", 32'(bus.o_exp_ready), 0);
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd10;
    cyc();
    bus.i_act_valid = 1'b0;
    chk("ready_back", 32'(bus.o_exp_ready), 1);
    chk("full_pass1", 32'(bus.o_pass_cnt), 1);
    cyc();
    bus.i_exp_valid = 1'b0;
    chk("refull_ready", 32'(bus.o_exp_ready), 0);
    for (int k = 0; k < 8; k++) begin
      bus.i_act_valid = 1'b1;
      bus.i_act_data  = 8'(11 + k);
      cyc();
    end
    idle_in();
    cyc();
    chk("full_pass9", 32'(bus.o_pass_cnt), 9);
    chk("full_fail0", 32'(bus.o_fail_cnt), 0);
    chk("empty_ready", 32'(bus.o_exp_ready), 1);

    // Underflow, then push+sample into empty is not bypassed
    bus.i_start = 1'b1;
    cyc();
    bus.i_start     = 1'b0;
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'h55;
    cyc();
    idle_in();
    chk("uf_flag",   32'(bus.o_underflow), 1);
    chk("uf_fail",   32'(bus.o_fail_cnt), 1);
    chk("uf_mm",     32'(bus.o_mismatch), 1);
    chk("uf_ff_idx", 32'(bus.o_first_fail_idx), 0);
    chk("uf_ff_exp", 32'(bus.o_first_fail_exp), 0);
    chk("uf_ff_act", 32'(bus.o_first_fail_act), 32'h55);
    cyc();
    chk("uf_mm_pulse", 32'(bus.o_mismatch), 0);
    chk("uf_sticky",   32'(bus.o_underflow), 1);
    bus.i_exp_valid = 1'b1;
    bus.i_exp_data  = 8'h33;
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'h33;
    cyc();
    bus.i_exp_valid = 1'b0;
    chk("nobypass_fail", 32'(bus.o_fail_cnt), 2);
    chk("nobypass_pass", 32'(bus.o_pass_cnt), 0);
    cyc();
    idle_in();
    chk("late_pass", 32'(bus.o_pass_cnt), 1);
    chk("ff_kept",   32'(bus.o_first_fail_act), 32'h55);

    // Start beats stop; drain with timeout
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    cyc();
    idle_in();
    chk("start_wins_ready", 32'(bus.o_exp_ready), 1);
    chk("start_wins_clear", 32'(bus.o_fail_cnt), 0);
    for (int k = 1; k <= 4; k++) begin
      bus.i_exp_valid = 1'b1;
      bus.i_exp_data  = 8'(k);
      cyc();
    end
    idle_in();
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd1;
    cyc();
    idle_in();
    bus.i_stop = 1'b1;
    cyc();
    idle_in();
    chk("drain_ready", 32'(bus.o_exp_ready), 0);
    chk("drain_not_done", 32'(bus.o_done), 0);
    n_idle = 0;
    while (!bus.o_done && n_idle < 40) begin
      cyc();
      n_idle++;
    end
    chk("drain_cycles",  32'(n_idle), 16);
    chk("drain_missing", 32'(bus.o_missing_cnt), 3);
    chk("drain_pass",    32'(bus.o_pass_cnt), 1);
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd7;
    cyc();
    idle_in();
    chk("done_ignores", 32'(bus.o_fail_cnt), 0);
    chk("done_holds",   32'(bus.o_done), 1);
    bus.i_start = 1'b1;
    cyc();
    idle_in();
    chk("restart_done",    32'(bus.o_done), 0);
    chk("restart_missing", 32'(bus.o_missing_cnt), 0);
    chk("restart_pass",    32'(bus.o_pass_cnt), 0);
    chk("restart_ready",   32'(bus.o_exp_ready), 1);

    // Asynchronous reset mid-RUN with 3 entries queued
    for (int k = 0; k < 4; k++) begin
      bus.i_exp_valid = 1'b1;
      bus.i_exp_data  = 8'(10 + k);
      cyc();
    end
    idle_in();
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd10;
    cyc();
    idle_in();
    chk("pre_reset_pass", 32'(bus.o_pass_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(any_out()), 0);
    @(negedge i_clk);
    rst_n = 1'b1;
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd5;
    cyc();
    idle_in();
    chk("post_reset_idle", 32'(bus.o_underflow), 0);
    bus.i_start = 1'b1;
    cyc();
    idle_in();
    bus.i_act_valid = 1'b1;
    bus.i_act_data  = 8'd11;
    cyc();
    idle_in();
    chk("post_reset_flushed", 32'(bus.o_underflow), 1);
    chk("post_reset_fail",    32'(bus.o_fail_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
